// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready handshakes on both sides.
//   ADD/SUB/NOR/NAND complete straight from IDLE into DONE. SRL/SLL/SRA
//   shift one bit per EXEC cycle, and MUL runs WIDTH shift-add steps.
//
// state | meaning
// IDLE  | ready for a request (in_ready = 1)
// EXEC  | iterating; cnt holds the steps still to do
// DONE  | result held on c/flags with out_valid = 1 until out_ready
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid / in_ready  request handshake for a, b, control
//   a, b                 operands (shifts use only b[$clog2(WIDTH)-1:0])
//   control              000 ADD, 001 SUB, 010 SRL, 011 NOR,
//                        100 NAND, 101 MUL, 110 SLL, 111 SRA
//   out_valid / out_ready result handshake
//   c                    result
//   flags                {overflow, carry, negative, zero}
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic [3:0]       flags
);

    localparam int AW = $clog2(WIDTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_SRL  = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_NAND = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_SLL  = 3'b110;
    localparam logic [2:0] OP_SRA  = 3'b111;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           state;
    logic [2:0]       op;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] work;   // shift operand, or multiplier / product low half
    logic [WIDTH-1:0] hi;     // product high half
    logic [WIDTH-1:0] mcand;  // multiplicand

    // Single-cycle results, computed directly from the live inputs so that
    // N = 0 operations can enter DONE on the accepting edge.
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic [AW-1:0]    amt;
    logic [CW-1:0]    n_iter;
    logic [WIDTH-1:0] imm_c;
    logic             imm_carry;
    logic             imm_ovf;

    always_comb begin
        add_full  = {1'b0, a} + {1'b0, b};
        sub_full  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        amt       = b[AW-1:0];
        imm_c     = a;  // a shift by zero passes a through with carry 0
        imm_carry = 1'b0;
        imm_ovf   = 1'b0;
        n_iter    = '0;
        case (control)
            OP_ADD: begin
                imm_c     = add_full[WIDTH-1:0];
                imm_carry = add_full[WIDTH];
                imm_ovf   = (a[WIDTH-1] == b[WIDTH-1]) &&
                            (add_full[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                imm_c     = sub_full[WIDTH-1:0];
                imm_carry = sub_full[WIDTH];
                imm_ovf   = (a[WIDTH-1] != b[WIDTH-1]) &&
                            (sub_full[WIDTH-1] != a[WIDTH-1]);
            end
            OP_NOR:  imm_c = ~(a | b);
            OP_NAND: imm_c = ~(a & b);
            OP_MUL:  n_iter = CW'(WIDTH);
            OP_SRL, OP_SLL, OP_SRA: n_iter = {1'b0, amt};
            default: imm_c = a;
        endcase
    end

    // One iteration step of the operation held in op.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] step_work;
    logic [WIDTH-1:0] step_hi;
    logic             step_carry;

    always_comb begin
        mul_sum    = {1'b0, hi} + (work[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        step_work  = work;
        step_hi    = hi;
        step_carry = 1'b0;
        case (op)
            OP_SLL: begin
                step_carry = work[WIDTH-1];
                step_work  = {work[WIDTH-2:0], 1'b0};
            end
            OP_SRL: begin
                step_carry = work[0];
                step_work  = {1'b0, work[WIDTH-1:1]};
            end
            OP_SRA: begin
                step_carry = work[0];
                step_work  = {work[WIDTH-1], work[WIDTH-1:1]};
            end
            OP_MUL: begin
                // {sum, work} shifted right by one: the add's carry lands in
                // the top of hi and hi's LSB moves into work's MSB.
                step_hi    = mul_sum[WIDTH:1];
                step_work  = {mul_sum[0], work[WIDTH-1:1]};
                step_carry = |mul_sum[WIDTH:1];
            end
            default: begin
                step_work = work;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op        <= OP_ADD;
            cnt       <= '0;
            work      <= '0;
            hi        <= '0;
            mcand     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            c         <= '0;
            flags     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        op       <= control;
                        work     <= a;
                        mcand    <= b;
                        hi       <= '0;
                        cnt      <= n_iter;
                        if (n_iter == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            c         <= imm_c;
                            flags     <= {imm_ovf, imm_carry, imm_c[WIDTH-1], imm_c == '0};
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    cnt  <= cnt - 1'b1;
                    work <= step_work;
                    hi   <= step_hi;
                    if (cnt == CW'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        c         <= step_work;
                        flags     <= {1'b0, step_carry, step_work[WIDTH-1], step_work == '0};
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Multi-cycle, width-parametrised ALU for the RISC datapath. It extends the combinational 8-bit ALU operation set with four additions:
- iterative variable-amount shifts;
- arithmetic right shift;
- shift-add multiply;
- a status-flag output.

Operands are accepted and results returned over valid/ready handshakes, so the execute stage can stall on long operations.

## Interface
- `WIDTH`, default 8: operand/result width. Must be a power of two, ≥ 4.
- `clk`  in  1: clock. All state updates on the rising edge.
- `rst`  in  1: reset. Asynchronous, active-high.
- `in_valid`  in  1: operand/op request valid.
- `in_ready`  out  1: block can accept a request.
- `a`  in  WIDTH: operand A.
- `b`  in  WIDTH: operand B. For shifts, only the shift amount `b[$clog2(WIDTH)-1:0]` is used; upper bits are ignored.
- `control`  in  3: operation select, encoded as follows.
  - 000 ADD
  - 001 SUB
  - 010 SRL
  - 011 NOR
  - 100 NAND
  - 101 MUL
  - 110 SLL
  - 111 SRA
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: consumer takes the result.
- `c`  out  WIDTH: result.
- `flags`  out  4: {overflow, carry, negative, zero}.

## Operation
- Request handling:
  - A request is accepted on a rising edge with `in_valid && in_ready`.
  - `a`, `b` and `control` are registered at acceptance; later input changes have no effect.
- State machine: IDLE, EXEC, DONE.
  - IDLE: `in_ready` = 1. On acceptance, go to DONE if the iteration count N = 0, otherwise go to EXEC with counter = N.
  - EXEC: one step per cycle; the counter decrements. Leave for DONE on the edge where the counter reaches 0.
  - DONE: `out_valid` = 1, and `c`/`flags` are held stable. On `out_valid && out_ready`, go to IDLE.
  - `in_ready` = 0 in EXEC and DONE.
- Iteration count N:
  - 0 for ADD, SUB, NOR, NAND.
  - The shift amount for SRL, SLL and SRA.
  - WIDTH for MUL.
- Arithmetic (WIDTH bits, wrap-around):
  - ADD: `c = a + b`; carry = carry-out.
  - SUB: `c = a + ~b + 1`; carry = carry-out, i.e. 1 when a ≥ b unsigned.
  - Overflow (ADD and SUB only) = two's-complement signed overflow.
- Logic:
  - NOR: `c = ~(a | b)`.
  - NAND: `c = ~(a & b)`.
  - Carry = 0 and overflow = 0.
- Shifts move one bit per EXEC cycle.
  - SRL and SLL fill with 0; SRA fills with the operand MSB.
  - Carry = the last bit shifted out, or 0 when the amount is 0.
  - Overflow = 0.
- MUL: unsigned shift-add over WIDTH steps.
  - `c` = low WIDTH bits of the product.
  - Carry = 1 iff the upper WIDTH bits of the full 2·WIDTH product are nonzero.
  - Overflow = 0.
- Flags common to all operations:
  - zero = (c == 0).
  - negative = `c[WIDTH-1]`.
- Reset:
  - While `rst` is high: state = IDLE, `in_ready` = 0, `out_valid` = 0, `c` = 0, `flags` = 0, counter = 0.
  - `in_ready` rises in the first cycle after `rst` deasserts.
  - Reset during EXEC or DONE aborts the operation; no result is ever presented for it.

## Timing
- Latency:
  - A request accepted at edge k shows `out_valid` = 1 after edge k+1+N.
  - N = 0 ops therefore have 1-cycle latency.
  - An 8-bit MUL has 9-cycle latency.
- `c` and `flags` update only on entry to DONE and hold until the output handshake.
- Output back-pressure: `out_ready` low holds DONE indefinitely, with outputs and `in_ready` = 0 stable.
- After the output handshake at edge m, IDLE is entered and `in_ready` = 1 in the following cycle.
  - Peak throughput is one N = 0 operation per 2 cycles.
  - There is no output-to-input bypass.
- `out_valid` never deasserts without a handshake, except on reset.
- `in_valid` presented while `in_ready` = 0 is ignored; the requester must hold it.

## Test plan
All scenarios use WIDTH = 8 and `out_ready` = 1 unless stated.
- ADD, a=0x0F, b=0x05 → c=0x14, flags=0000, `out_valid` 1 cycle after acceptance. SUB on the same operands → c=0x0A, carry=1.
- SUB, a=0x05, b=0x0F → c=0xF6, carry=0, negative=1. ADD, a=0x7F, b=0x01 → c=0x80, overflow=1, negative=1.
- NAND, a=0x0F, b=0x05 → c=0xFA. NOR on the same operands → c=0xF0. Both have carry=0 and overflow=0.
- Shifts:
  - SLL, a=0x0F, b=0x05 → c=0xE0, carry=1, latency 6.
  - SRA, a=0x80, b=0x03 → c=0xF0.
  - SRL, a=0x80, b=0x08 (amount field = 0) → c=0x80, carry=0, latency 1.
- MUL, a=0x0F, b=0x05 → c=0x4B, carry=0, latency 9. MUL, a=0x20, b=0x10 → c=0x00, zero=1, carry=1.
- Control cases:
  - Back-pressure: hold `out_ready`=0 for 5 cycles after `out_valid` → `c`/`flags` stable and `in_ready`=0.
  - Reset: assert `rst` in the 4th EXEC cycle of a MUL → `out_valid` and `c` go to 0 immediately, and `in_ready`=1 the cycle after release.
  - Input change: alter `a`, `b` and `control` after acceptance → the result is unchanged.
